// File: rtl/cpu_ma_pkg.sv
// cpu_ma_pkg
//   Shared types for the memory-access stage: access mode, access size,
//   write-back source selector and the canonical NOP encoding used to
//   fill ma_ir when no real instruction has retired.
package cpu_ma_pkg;

  typedef enum logic [1:0] {
    MA_X     = 2'd0,
    MA_LOAD  = 2'd1,
    MA_STORE = 2'd2
  } ma_mode_t;

  typedef enum logic [2:0] {
    MA_B  = 3'd0,
    MA_H  = 3'd1,
    MA_W  = 3'd2,
    MA_BU = 3'd3,
    MA_HU = 3'd4
  } ma_size_t;

  typedef enum logic [1:0] {
    WB_SRC_X   = 2'd0,
    WB_SRC_ALU = 2'd1,
    WB_SRC_MEM = 2'd2,
    WB_SRC_PC4 = 2'd3
  } wb_src_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/cpu_ma_align.sv
// cpu_ma_align
//   Purely combinational byte-lane logic for cpu_ma.
//   Request side (from EX): address offset, size and store data produce the
//   lane-replicated write data, the byte mask and the misaligned flag.
//   Response side (captured request): offset, size and the memory read word
//   produce the sign-/zero-extended load result.
// Ports
//   req_off        in   2   address bits [1:0] of the incoming access
//   req_size       in   ma_size_t
//   req_data       in   32  store data (rs2)
//   req_wdata      out  32  store data replicated into every matching lane
//   req_mask       out  4   byte enables
//   req_misaligned out  1   H/HU on odd address or W not word-aligned
//   rsp_off        in   2   address bits [1:0] of the pending load
//   rsp_size       in   ma_size_t
//   rsp_rdata      in   32  word returned by memory
//   rsp_result     out  32  extracted and extended load value
module cpu_ma_align
  import cpu_ma_pkg::*;
(
  input  logic [1:0]  req_off,
  input  ma_size_t    req_size,
  input  logic [31:0] req_data,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_mask,
  output logic        req_misaligned,
  input  logic [1:0]  rsp_off,
  input  ma_size_t    rsp_size,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_result
);

  logic [31:0] rsp_shifted;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  // Store data is replicated rather than shifted, so the mask alone picks the lane.
  always_comb begin
    req_wdata      = req_data;
    req_mask       = 4'b1111;
    req_misaligned = 1'b0;
    case (req_size)
      MA_B, MA_BU: begin
        req_wdata = {4{req_data[7:0]}};
        req_mask  = 4'b0001 << req_off;
      end
      MA_H, MA_HU: begin
        req_wdata      = {2{req_data[15:0]}};
        req_mask       = 4'b0011 << {req_off[1], 1'b0};
        req_misaligned = req_off[0];
      end
      MA_W: begin
        req_misaligned = (req_off != 2'b00);
      end
      default: begin
        req_misaligned = (req_off != 2'b00);
      end
    endcase
  end

  assign rsp_shifted = rsp_rdata >> {rsp_off, 3'b000};
  assign rsp_byte    = rsp_shifted[7:0];
  assign rsp_half    = rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];

  always_comb begin
    rsp_result = rsp_rdata;
    case (rsp_size)
      MA_B:    rsp_result = {{24{rsp_byte[7]}}, rsp_byte};
      MA_BU:   rsp_result = {24'h000000, rsp_byte};
      MA_H:    rsp_result = {{16{rsp_half[15]}}, rsp_half};
      MA_HU:   rsp_result = {16'h0000, rsp_half};
      default: rsp_result = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/cpu_ma.sv
// cpu_ma
//   Memory-access pipeline stage between cpu_ex and write-back.
//   Non-memory instructions retire one edge after acceptance. Aligned loads
//   and stores enter BUSY and hold a registered dmem request until dmem_ack
//   or until DMEM_TIMEOUT BUSY cycles pass without an ack (0 disables the
//   timeout). Misaligned accesses retire immediately with a pulse on
//   ma_misaligned and no memory traffic.
// Ports
//   clk_i, reset_ni                  clock, synchronous active-low reset
//   ex_*                             instruction offered by EX (ex_valid qualifies)
//   ma_ready                         stage is IDLE and accepts this cycle
//   dmem_*                           req/ack data-memory interface
//   ma_valid, ma_ir, ma_wb_*         retiring instruction towards WB
//   ma_misaligned, ma_fault          one-cycle error pulses with the retire
//   hz_ma_wb_*                       forwarding/hazard view for cpu_id
module cpu_ma
  import cpu_ma_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        ex_valid,
  input  logic [31:0] ex_ir,
  input  logic [31:0] ex_alu_result,
  input  ma_mode_t    ex_ma_mode,
  input  ma_size_t    ex_ma_size,
  input  logic [31:0] ex_ma_data,
  input  wb_src_t     ex_wb_src,
  input  logic [31:0] ex_wb_data,
  output logic        ma_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_write_data,
  output logic [3:0]  dmem_write_mask,
  input  logic [31:0] dmem_read_data,
  input  logic        dmem_ack,
  output logic        ma_valid,
  output logic [31:0] ma_ir,
  output logic [31:0] ma_wb_data,
  output logic        ma_wb_enable,
  output logic        ma_misaligned,
  output logic        ma_fault,
  output logic [4:0]  hz_ma_wb_addr,
  output logic [31:0] hz_ma_wb_data,
  output logic        hz_ma_wb_enable,
  output logic        hz_ma_wb_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [31:0] cap_ir;
  logic [1:0]  cap_off;
  ma_size_t    cap_size;
  logic        cap_is_load;
  wb_src_t     cap_wb_src;
  logic [15:0] timeout_cnt;

  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        req_misaligned;
  logic [31:0] rsp_result;
  logic        ex_is_mem;
  logic        cap_writes_rd;

  cpu_ma_align u_align (
    .req_off        (ex_alu_result[1:0]),
    .req_size       (ex_ma_size),
    .req_data       (ex_ma_data),
    .req_wdata      (req_wdata),
    .req_mask       (req_mask),
    .req_misaligned (req_misaligned),
    .rsp_off        (cap_off),
    .rsp_size       (cap_size),
    .rsp_rdata      (dmem_read_data),
    .rsp_result     (rsp_result)
  );

  assign ma_ready      = (state == IDLE);
  assign ex_is_mem     = (ex_ma_mode == MA_LOAD) || (ex_ma_mode == MA_STORE);
  assign cap_writes_rd = (cap_wb_src != WB_SRC_X) && (cap_ir[11:7] != 5'd0);

  // Retire pulses and ma_wb_enable default low each edge so they only
  // assert in the cycle an instruction actually completes.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state           <= IDLE;
      timeout_cnt     <= '0;
      cap_ir          <= NOP;
      cap_off         <= 2'b00;
      cap_size        <= MA_W;
      cap_is_load     <= 1'b0;
      cap_wb_src      <= WB_SRC_X;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_write_data <= '0;
      dmem_write_mask <= 4'b0000;
      ma_valid        <= 1'b0;
      ma_ir           <= NOP;
      ma_wb_data      <= '0;
      ma_wb_enable    <= 1'b0;
      ma_misaligned   <= 1'b0;
      ma_fault        <= 1'b0;
    end else begin
      ma_valid      <= 1'b0;
      ma_wb_enable  <= 1'b0;
      ma_misaligned <= 1'b0;
      ma_fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!ex_is_mem) begin
              ma_valid     <= 1'b1;
              ma_ir        <= ex_ir;
              ma_wb_data   <= ex_wb_data;
              ma_wb_enable <= (ex_wb_src != WB_SRC_X) && (ex_ir[11:7] != 5'd0);
            end else if (req_misaligned) begin
              ma_valid      <= 1'b1;
              ma_ir         <= ex_ir;
              ma_wb_data    <= '0;
              ma_misaligned <= 1'b1;
            end else begin
              state           <= BUSY;
              timeout_cnt     <= '0;
              cap_ir          <= ex_ir;
              cap_off         <= ex_alu_result[1:0];
              cap_size        <= ex_ma_size;
              cap_is_load     <= (ex_ma_mode == MA_LOAD);
              cap_wb_src      <= ex_wb_src;
              dmem_req        <= 1'b1;
              dmem_we         <= (ex_ma_mode == MA_STORE);
              dmem_addr       <= {ex_alu_result[31:2], 2'b00};
              dmem_write_data <= (ex_ma_mode == MA_STORE) ? req_wdata : 32'h0;
              dmem_write_mask <= (ex_ma_mode == MA_STORE) ? req_mask : 4'b0000;
            end
          end
        end
        BUSY: begin
          // An ack in the final timeout cycle still completes normally.
          if (dmem_ack) begin
            state           <= IDLE;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_write_mask <= 4'b0000;
            ma_valid        <= 1'b1;
            ma_ir           <= cap_ir;
            ma_wb_data      <= cap_is_load ? rsp_result : 32'h0;
            ma_wb_enable    <= cap_is_load && cap_writes_rd;
          end else if ((DMEM_TIMEOUT != 0) && (timeout_cnt == 16'(DMEM_TIMEOUT - 1))) begin
            state           <= IDLE;
            timeout_cnt     <= '0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_write_mask <= 4'b0000;
            ma_valid        <= 1'b1;
            ma_ir           <= cap_ir;
            ma_wb_data      <= '0;
            ma_fault        <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // While a load is outstanding its rd is announced but the data is not yet
  // forwardable, so ID must stall rather than bypass.
  always_comb begin
    hz_ma_wb_addr   = ma_ir[11:7];
    hz_ma_wb_data   = ma_wb_data;
    hz_ma_wb_enable = ma_wb_enable & ma_valid;
    hz_ma_wb_valid  = 1'b1;
    if (state == BUSY) begin
      hz_ma_wb_addr   = cap_ir[11:7];
      hz_ma_wb_data   = 32'h0;
      hz_ma_wb_enable = cap_is_load && (cap_ir[11:7] != 5'd0);
      hz_ma_wb_valid  = !cap_is_load;
    end
  end

endmodule
